// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/SUB/logic/SLT/SLL and a shift-add MUL with valid/ready handshakes.
// Define ALU_MUL_EN to build the multiplier; without it opcode 111 is reported as an illegal op.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] R2,
    input  logic [WIDTH-1:0] R3,
    input  logic [2:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R0,
    output logic             overflow,
    output logic             zero,
    output logic             carry
);

    // state | meaning
    // IDLE  | no operation held, ready to accept
    // BUSY  | multiply in progress, one partial product per cycle
    // DONE  | R0 and flags valid, waiting for out_ready
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             start_mul;
    logic             mul_last;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SW-1:0]    sh_amt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign accept  = in_valid && in_ready;
    assign add_sum = {1'b0, R2} + {1'b0, R3};
    assign sub_sum = {1'b0, R2} + {1'b0, ~R3} + (WIDTH+1)'(1);
    assign sh_amt  = R3[SW-1:0];

`ifdef ALU_MUL_EN
    logic [SW-1:0]      iter_cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier;

    assign start_mul = accept && (ALUOp == 3'b111);
    assign mul_last  = (iter_cnt == SW'(WIDTH-1));
    assign prod_nxt  = mplier[0] ? (acc + mcand) : acc;
`else
    assign start_mul = 1'b0;
    assign mul_last  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = start_mul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mul_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = start_mul ? BUSY : DONE;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Opcode 111 only lands here when the multiplier is not built: flag it as illegal.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUOp)
            3'b000: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (R2[WIDTH-1] == R3[WIDTH-1]) && (add_sum[WIDTH-1] != R2[WIDTH-1]);
            end
            3'b001: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (R2[WIDTH-1] != R3[WIDTH-1]) && (sub_sum[WIDTH-1] != R2[WIDTH-1]);
            end
            3'b010: alu_res = R2 & R3;
            3'b011: alu_res = R2 | R3;
            3'b100: alu_res = R2 ^ R3;
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(R2) < $signed(R3))};
            3'b110: alu_res = R2 << sh_amt;
            default: begin
                alu_res = '0;
                alu_v   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R0       <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
`ifdef ALU_MUL_EN
            iter_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
`endif
        end else begin
`ifdef ALU_MUL_EN
            if (start_mul) begin
                iter_cnt <= '0;
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, R2};
                mplier   <= R3;
            end else if (accept) begin
                R0       <= alu_res;
                overflow <= alu_v;
                zero     <= (alu_res == '0);
                carry    <= alu_c;
            end else if (state == BUSY) begin
                acc    <= prod_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (mul_last) begin
                    iter_cnt <= '0;
                    R0       <= prod_nxt[WIDTH-1:0];
                    carry    <= |prod_nxt[2*WIDTH-1:WIDTH];
                    overflow <= |prod_nxt[2*WIDTH-1:WIDTH];
                    zero     <= (prod_nxt[WIDTH-1:0] == '0);
                end else begin
                    iter_cnt <= iter_cnt + SW'(1);
                end
            end
`else
            if (accept) begin
                R0       <= alu_res;
                overflow <= alu_v;
                zero     <= (alu_res == '0);
                carry    <= alu_c;
            end
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=8.
// Covers the MUL path when ALU_MUL_EN is defined, otherwise the illegal-op path.
module tb_multicycle_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] R2;
    logic [7:0] R3;
    logic [2:0] ALUOp;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] R0;
    logic       overflow;
    logic       zero;
    logic       carry;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .R2        (R2),
        .R3        (R3),
        .ALUOp     (ALUOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R0        (R0),
        .overflow  (overflow),
        .zero      (zero),
        .carry     (carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        ALUOp    = op;
        R2       = a;
        R3       = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [12:0] obs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        R2        = '0;
        R3        = '0;
        ALUOp     = '0;
        #12;
        obs = {in_ready, out_valid, R0, overflow, zero, carry};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, {1'b1, 1'b0, 8'h00, 3'b000});
        end
        @(negedge clk);
        rst      = 1'b0;
        ALUOp    = 3'b000;
        R2       = 8'h01;
        R3       = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        obs = {1'b0, out_valid, R0, overflow, zero, carry};
        n_checks++;
        if (obs !== {1'b0, 1'b1, 8'h02, 3'b000}) begin
            n_fail++;
            $display("FAIL first_accept_after_reset: got %h expected %h", obs, {1'b0, 1'b1, 8'h02, 3'b000});
        end
    endtask

    task automatic test_ops;
        logic [2:0]  op_t [12];
        logic [7:0]  a_t  [12];
        logic [7:0]  b_t  [12];
        logic [7:0]  r_t  [12];
        logic [2:0]  f_t  [12];
        logic [11:0] obs;
        logic [11:0] exp_v;
        // flags packed as {overflow, zero, carry}
        op_t = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b110, 3'b101, 3'b101, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001};
        a_t  = '{8'hF0,  8'hF0,  8'hAA,  8'h01,  8'h81,  8'h01,  8'hFE,  8'h80,  8'h01,  8'hFF,  8'h7F,  8'h05};
        b_t  = '{8'h3C,  8'h0F,  8'hAA,  8'h0B,  8'h09,  8'hFE,  8'h01,  8'h01,  8'h02,  8'h01,  8'h01,  8'h05};
        r_t  = '{8'h30,  8'hFF,  8'h00,  8'h08,  8'h02,  8'h00,  8'h01,  8'h7F,  8'hFF,  8'h00,  8'h80,  8'h00};
        f_t  = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b101, 3'b000, 3'b011, 3'b100, 3'b011};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            do_op(op_t[i], a_t[i], b_t[i]);
            obs   = {out_valid, R0, overflow, zero, carry};
            exp_v = {1'b1, r_t[i], f_t[i]};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL op_vector_%0d (op=%b a=%h b=%h): got %h expected %h", i, op_t[i], a_t[i], b_t[i], obs, exp_v);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL result_consumed: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  a_t [4];
        logic [7:0]  b_t [4];
        logic [7:0]  r_t [4];
        logic [2:0]  f_t [4];
        logic [12:0] obs;
        logic [12:0] exp_v;
        a_t = '{8'h01, 8'h0A, 8'h7F, 8'h80};
        b_t = '{8'h02, 8'h14, 8'h01, 8'h80};
        r_t = '{8'h03, 8'h1E, 8'h80, 8'h00};
        f_t = '{3'b000, 3'b000, 3'b100, 3'b111};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ALUOp    = 3'b000;
            R2       = a_t[i];
            R3       = b_t[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            obs   = {in_ready, out_valid, R0, overflow, zero, carry};
            exp_v = {1'b1, 1'b1, r_t[i], f_t[i]};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stream_result_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        @(negedge clk);
        R2 = 8'h05;
        R3 = 8'h05;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, R0} !== {1'b1, 8'h0A}) begin
            n_fail++;
            $display("FAIL stream_before_stall: got %h expected %h", {out_valid, R0}, {1'b1, 8'h0A});
        end
        @(negedge clk);
        out_ready = 1'b0;
        R2        = 8'h06;
        R3        = 8'h06;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            obs   = {in_ready, out_valid, R0, overflow, zero, carry};
            exp_v = {1'b0, 1'b1, 8'h0A, 3'b000};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, R0} !== {1'b1, 8'h0C}) begin
            n_fail++;
            $display("FAIL stream_after_stall: got %h expected %h", {out_valid, R0}, {1'b1, 8'h0C});
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul;
        logic [7:0]  a_t [2];
        logic [7:0]  b_t [2];
        logic [7:0]  r_t [2];
        logic [2:0]  f_t [2];
        int          lat;
        logic        ready_seen;
        logic [11:0] obs;
        a_t = '{8'h0F, 8'h10};
        b_t = '{8'h11, 8'h10};
        r_t = '{8'hFF, 8'h00};
        f_t = '{3'b000, 3'b111};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_op(3'b111, a_t[i], b_t[i]);
            lat        = 21;
            ready_seen = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                if (out_valid) begin
                    lat = k - 1;
                    break;
                end
                ready_seen = ready_seen | in_ready;
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (lat != 8) begin
                n_fail++;
                $display("FAIL mul_latency_%0d: got %0d cycles expected 8", i, lat);
            end
            n_checks++;
            if (ready_seen !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy_in_ready_%0d: got %b expected 0", i, ready_seen);
            end
            obs = {out_valid, R0, overflow, zero, carry};
            n_checks++;
            if (obs !== {1'b1, r_t[i], f_t[i]}) begin
                n_fail++;
                $display("FAIL mul_result_%0d: got %h expected %h", i, obs, {1'b1, r_t[i], f_t[i]});
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [12:0] obs;
        logic        stale;
        out_ready = 1'b1;
        do_op(3'b111, 8'h0F, 8'h11);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        obs = {in_ready, out_valid, R0, overflow, zero, carry};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_in_busy: got %h expected %h", obs, {1'b1, 1'b0, 8'h00, 3'b000});
        end
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            stale = stale | out_valid;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL no_stale_result: out_valid seen %b expected 0", stale);
        end
        do_op(3'b000, 8'h03, 8'h04);
        n_checks++;
        if ({out_valid, R0, overflow, zero, carry} !== {1'b1, 8'h07, 3'b000}) begin
            n_fail++;
            $display("FAIL add_after_reset: got %h expected %h", {out_valid, R0, overflow, zero, carry}, {1'b1, 8'h07, 3'b000});
        end
    endtask
`else
    task automatic test_illegal_op;
        logic [11:0] obs;
        out_ready = 1'b1;
        do_op(3'b111, 8'h12, 8'h34);
        obs = {out_valid, R0, overflow, zero, carry};
        n_checks++;
        if (obs !== {1'b1, 8'h00, 3'b110}) begin
            n_fail++;
            $display("FAIL illegal_op: got %h expected %h", obs, {1'b1, 8'h00, 3'b110});
        end
    endtask

    task automatic test_reset_mid;
        logic [12:0] obs;
        logic        stale;
        out_ready = 1'b0;
        do_op(3'b000, 8'h09, 8'h09);
        n_checks++;
        if ({out_valid, R0} !== {1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL held_before_reset: got %h expected %h", {out_valid, R0}, {1'b1, 8'h12});
        end
        #2;
        rst = 1'b1;
        #1;
        obs = {in_ready, out_valid, R0, overflow, zero, carry};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_in_done: got %h expected %h", obs, {1'b1, 1'b0, 8'h00, 3'b000});
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        stale     = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            stale = stale | out_valid;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL no_stale_result: out_valid seen %b expected 0", stale);
        end
        do_op(3'b000, 8'h03, 8'h04);
        n_checks++;
        if ({out_valid, R0, overflow, zero, carry} !== {1'b1, 8'h07, 3'b000}) begin
            n_fail++;
            $display("FAIL add_after_reset: got %h expected %h", {out_valid, R0, overflow, zero, carry}, {1'b1, 8'h07, 3'b000});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_illegal_op();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width (>=4).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operands and opcode valid.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 R2  input  WIDTH  operand A.
REQ-007 R3  input  WIDTH  operand B.
REQ-008 ALUOp  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL (B[log2 WIDTH-1:0]), 111 MUL.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 R0  output  WIDTH  registered result.
REQ-012 overflow, zero, carry  output  1 each  registered flags.

Function
REQ-013 Accept occurs on the rising edge where in_valid && in_ready; R2, R3 and ALUOp are captured only then.
REQ-014 FSM states IDLE, BUSY, DONE. IDLE->DONE on accept of non-MUL op. IDLE->BUSY on accept of MUL. BUSY->DONE when the iteration counter reaches WIDTH-1. DONE->IDLE on out_ready, or DONE->DONE/BUSY on out_ready with a simultaneous accept.
REQ-015 in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back single-cycle ops sustain one result per cycle.
REQ-016 out_valid = (state==DONE); R0 and flags stay stable while out_valid && !out_ready.
REQ-017 Non-MUL latency: out_valid high in the cycle after the accept edge.
REQ-018 MUL latency: out_valid high WIDTH cycles after the accept edge; in_ready low throughout BUSY.
REQ-019 ADD/SUB: full WIDTH+1-bit sum; carry = bit WIDTH (for SUB, carry = 1 means no borrow, A + ~B + 1); overflow = signed overflow of the WIDTH-bit result.
REQ-020 Logic ops, SLT and SLL: carry = 0, overflow = 0; SLT R0 = {WIDTH-1 zeros, A<B signed}.
REQ-021 MUL: shift-add, one partial product per cycle; R0 = low WIDTH bits of unsigned A*B; carry = 1 if any upper-half bit is nonzero; overflow = carry.
REQ-022 zero = (R0 == 0) for every op.
REQ-023 in_valid outside in_ready is ignored and leaves no state change.

Reset
REQ-024 rst asserted forces IDLE immediately, independent of clk: R0 = 0, overflow = 0, zero = 0, carry = 0, out_valid = 0, iteration counter = 0.
REQ-025 rst asserted during BUSY or DONE discards the operation; no result is produced for it after release.
REQ-026 First accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro ALU_MUL_EN: when defined, MUL behaves per REQ-018/021.
REQ-028 When ALU_MUL_EN is undefined, the multiplier and BUSY datapath are absent; opcode 111 completes with non-MUL latency, giving R0 = 0, zero = 1, carry = 0 and overflow = 1 (illegal-op indication).

Verification (WIDTH=8 unless stated)
REQ-029 ADD 8'hFF+8'h01, out_ready=1 -> next cycle R0=00, carry=1, zero=1, overflow=0.
REQ-030 SUB 8'h80-8'h01 -> R0=7F, overflow=1, carry=1; SLT 8'hFE,8'h01 -> R0=01.
REQ-031 MUL 8'h0F*8'h11 with ALU_MUL_EN -> out_valid exactly 8 cycles after accept, R0=FF, carry=0; 8'h10*8'h10 -> R0=00, carry=1, overflow=1, zero=1.
REQ-032 Stream 4 ADDs with in_valid and out_ready held high -> 4 results on 4 consecutive cycles; drop out_ready for 3 cycles mid-stream -> R0 held, in_ready low, no result lost.
REQ-033 Assert rst in BUSY cycle 3 of a MUL -> outputs zero immediately; after release, no stale out_valid; a following ADD 3+4 returns 07.
REQ-034 Without ALU_MUL_EN, opcode 111 -> next cycle R0=00, zero=1, overflow=1, carry=0.
